// File: rtl/cpu_pkg.sv
// Shared core types: reset vector, memory regions and the fetch entry
// handed from fetch to decode.
package cpu_pkg;

  localparam logic [31:0] RESET_PC    = 32'h9fc0_0000;
  localparam logic [11:0] REGION_BOOT = 12'h9fc;
  localparam logic [11:0] REGION_RAM  = 12'h800;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_t;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) &&
           ((a[31:20] == REGION_BOOT) || (a[31:20] == REGION_RAM));
  endfunction

endpackage

// File: rtl/if_queue.sv
// Circular DEPTH-entry queue of fetch entries with flush.
// Push is honoured when not full, or when full and popping.
module if_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_t        din,
  input  logic          pop,
  input  logic          flush,
  output fetch_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_t        mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr      <= nxt(wr);
      end
      if (do_pop) rd <= nxt(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC, address check, redirect and a 2-entry queue.
// Optional IF_STAT_EN adds a saturating stall_cnt output.
module if_fetch #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
`ifdef IF_STAT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic          halted;
  logic          pop;
  logic          fetch_fire;
  logic          ok;
  fetch_t        q_in;
  fetch_t        q_out;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  assign im_addr    = pc;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign fetch_fire = !halted && (!full || pop) && !redirect_valid;
  assign ok         = addr_ok(pc);

  always_comb begin
    q_in.pc    = pc;
    q_in.instr = ok ? im_data : 32'h0;
    q_in.adel  = !ok;
  end

  // Empty queue shows zeros, not a stale entry.
  assign out_pc    = empty ? 32'h0 : q_out.pc;
  assign out_instr = empty ? 32'h0 : q_out.instr;
  assign out_adel  = empty ? 1'b0  : q_out.adel;

  if_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch_fire),
    .din   (q_in),
    .pop   (pop && !redirect_valid),
    .flush (redirect_valid),
    .dout  (q_out),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (fetch_fire) begin
      if (ok) pc     <= pc + 32'd4;
      else    halted <= 1'b1;
    end
  end

`ifdef IF_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!halted && !redirect_valid && !fetch_fire
                 && stall_cnt != 32'hffff_ffff) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scenario bench for if_fetch with a queue-based scoreboard model.
// Define IF_STAT_EN to also check stall_cnt.
module tb_if_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;
`ifdef IF_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_t      m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_stall;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h9fc0_0000: return 32'h2408_0001;
      32'h9fc0_0004: return 32'h2409_0002;
      default:       return a ^ 32'h3c5a_0f00;
    endcase
  endfunction

  always_comb im_data = mem_word(im_addr);

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_adel       (out_adel)
`ifdef IF_STAT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic model_reset();
    m_q.delete();
    m_pc    = 32'h9fc0_0000;
    m_halt  = 0;
    m_stall = 0;
  endtask

  // Advance one cycle: update the reference model, then wait for negedge.
  task automatic tick();
    bit     pop, fire, ok;
    fetch_t e;
    pop  = (m_q.size() != 0) && out_ready;
    fire = !m_halt && (m_q.size() < 2 || pop) && !redirect_valid;
    if (!m_halt && !redirect_valid && !fire && m_stall != 32'hffff_ffff)
      m_stall++;
    if (redirect_valid) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_halt = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (fire) begin
        ok = (m_pc[1:0] == 2'b00) &&
             (m_pc[31:20] == 12'h9fc || m_pc[31:20] == 12'h800);
        e.pc = m_pc;
        if (ok) begin
          e.instr = mem_word(m_pc);
          e.adel  = 1'b0;
          m_pc    = m_pc + 32'd4;
        end else begin
          e.instr = 32'h0;
          e.adel  = 1'b1;
          m_halt  = 1;
        end
        m_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_pc, out_instr, out_adel} !== 65'h0) begin
      n_bad++;
      $display("FAIL reset_out got %h %h %b want 0", out_pc, out_instr, out_adel);
    end
    n_cmp++;
    if (im_addr !== 32'h9fc0_0000) begin
      n_bad++; $display("FAIL reset_addr got %h want 9fc00000", im_addr);
    end
`ifdef IF_STAT_EN
    n_cmp++;
    if (stall_cnt !== 32'h0) begin
      n_bad++; $display("FAIL reset_stall got %0d want 0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (im_addr !== 32'h9fc0_0000 + 32'(4 * i)) begin
        n_bad++; $display("FAIL boot_addr got %h want %h", im_addr, 32'h9fc0_0000 + 32'(4 * i));
      end
      n_cmp++;
      if (out_valid !== (i > 0)) begin
        n_bad++; $display("FAIL boot_valid got %b want %b", out_valid, i > 0);
      end
      if (i > 0) begin
        n_cmp++;
        if (out_pc !== 32'h9fc0_0000 + 32'(4 * (i - 1)) ||
            {out_pc, out_instr, out_adel} !== m_q[0]) begin
          n_bad++; $display("FAIL boot_head got %h %h %b want %h", out_pc, out_instr, out_adel, m_q[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ea = 32'h9fc0_0000 + 32'(4 * ((i < 2) ? i : 2));
      n_cmp++;
      if (im_addr !== ea) begin
        n_bad++; $display("FAIL bp_addr got %h want %h", im_addr, ea);
      end
      if (i > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h9fc0_0000 ||
            out_instr !== 32'h2408_0001) begin
          n_bad++; $display("FAIL bp_hold got %b %h %h want 1 9fc00000 24080001", out_valid, out_pc, out_instr);
        end
      end
      tick();
    end
`ifdef IF_STAT_EN
    n_cmp++;
    if (stall_cnt !== 32'd4 || stall_cnt !== m_stall) begin
      n_bad++; $display("FAIL bp_stall got %0d want 4", stall_cnt);
    end
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h9fc0_0000 + 32'(4 * k) ||
          {out_pc, out_instr, out_adel} !== m_q[0]) begin
        n_bad++; $display("FAIL bp_drain got %b %h want %h", out_valid, out_pc, 32'h9fc0_0000 + 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || im_addr !== m_pc) begin
      n_bad++; $display("FAIL rd_pre got %b %h want 1 %h", out_valid, im_addr, m_pc);
    end
    out_ready = 1'b1;
    redirect(32'h8000_0000);
    n_cmp++;
    if (out_valid !== 1'b0 || im_addr !== 32'h8000_0000) begin
      n_bad++; $display("FAIL rd_flush got %b %h want 0 80000000", out_valid, im_addr);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 + 32'(4 * k) ||
          {out_pc, out_instr, out_adel} !== m_q[0]) begin
        n_bad++; $display("FAIL rd_seq got %b %h want %h", out_valid, out_pc, 32'h8000_0000 + 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_misaligned();
    out_ready = 1'b1;
    redirect(32'h8000_0002);
    n_cmp++;
    if (out_valid !== 1'b0 || im_addr !== 32'h8000_0002) begin
      n_bad++; $display("FAIL mis_pre got %b %h want 0 80000002", out_valid, im_addr);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8000_0002 ||
        out_instr !== 32'h0 || out_adel !== 1'b1) begin
      n_bad++; $display("FAIL mis_entry got %b %h %h %b want 1 80000002 0 1", out_valid, out_pc, out_instr, out_adel);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || im_addr !== 32'h8000_0002) begin
        n_bad++; $display("FAIL mis_halt got %b %h want 0 80000002", out_valid, im_addr);
      end
      tick();
    end
    redirect(32'h9fc0_0000);
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h9fc0_0000 ||
        {out_pc, out_instr, out_adel} !== m_q[0]) begin
      n_bad++; $display("FAIL mis_resume got %b %h want 1 9fc00000", out_valid, out_pc);
    end
  endtask

  task automatic test_region_cross();
    out_ready = 1'b1;
    redirect(32'h800f_fffc);
    tick();
    n_cmp++;
    if (out_pc !== 32'h800f_fffc || out_adel !== 1'b0 ||
        im_addr !== 32'h8010_0000) begin
      n_bad++; $display("FAIL rc_first got %h %b %h want 800ffffc 0 80100000", out_pc, out_adel, im_addr);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8010_0000 ||
        out_adel !== 1'b1 || out_instr !== 32'h0) begin
      n_bad++; $display("FAIL rc_adel got %b %h %b %h want 1 80100000 1 0", out_valid, out_pc, out_adel, out_instr);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || im_addr !== 32'h8010_0000) begin
      n_bad++; $display("FAIL rc_halt got %b %h want 0 80100000", out_valid, im_addr);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    redirect(32'h9fc0_0000);
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || im_addr !== 32'h9fc0_0008) begin
      n_bad++; $display("FAIL rm_full got %b %h want 1 9fc00008", out_valid, im_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
      n_bad++; $display("FAIL rm_async got %b %h want 0 0", out_valid, out_pc);
    end
    @(negedge clk);
    model_reset();
    n_cmp++;
    if (im_addr !== 32'h9fc0_0000) begin
      n_bad++; $display("FAIL rm_addr got %h want 9fc00000", im_addr);
    end
`ifdef IF_STAT_EN
    n_cmp++;
    if (stall_cnt !== 32'h0) begin
      n_bad++; $display("FAIL rm_stall got %0d want 0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || {out_pc, out_instr, out_adel} !== m_q[0] ||
        out_pc !== 32'h9fc0_0000) begin
      n_bad++; $display("FAIL rm_restart got %b %h want 1 9fc00000", out_valid, out_pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_region_cross();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
